// File: rtl/axi_bridge_pkg.sv
// Shared encodings, burst context and address-step helper for the AXI-to-SRAM bridge.
package axi_bridge_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WR_RESP
  } state_e;

  // Burst context latched on an address handshake
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ax_ctx_t;

  // Byte address of the next beat; sizes above a word clamp to a word, illegal wraps behave as INCR
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0]  addr,
    input logic [SIZE_W-1:0]  size,
    input logic [LEN_W-1:0]   len,
    input logic [BURST_W-1:0] burst
  );
    logic [1:0]        sz;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    logic              wrap_ok;
    sz      = (size > 3'd2) ? 2'd2 : size[1:0];
    step    = ADDR_W'(1) << sz;
    inc     = addr + step;
    mask    = ((ADDR_W'(len) + ADDR_W'(1)) << sz) - ADDR_W'(1);
    wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~mask) | (inc & mask)) : inc;
      default:     next_addr = inc;
    endcase
  endfunction

endpackage

// File: rtl/axi_sram_bridge_skid.sv
// Two-entry FIFO between SRAM read data and the R channel; space is guaranteed by the issuer's credit check.
module axi_skid_buf
  import axi_bridge_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] data_q [2];
  logic [1:0]   last_q;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = data_q[rd_ptr];
  assign out_last  = last_q[rd_ptr];
  assign pop       = out_valid && out_ready;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (in_valid) begin
        data_q[wr_ptr] <= in_data;
        last_q[wr_ptr] <= in_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(in_valid) - 2'(pop);
    end
  end

endmodule

// File: rtl/axi_sram_bridge.sv
// AXI slave terminating one master port onto a synchronous single-port SRAM, one burst at a time.
module axi_sram_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned RAM_AW = 16,
  parameter int unsigned ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [LEN_W-1:0]    aw_len,
  input  logic [SIZE_W-1:0]   aw_size,
  input  logic [BURST_W-1:0]  aw_burst,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [STRB_W-1:0]   w_strb,
  input  logic                w_last,
  input  logic                w_valid,
  output logic                w_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [RESP_W-1:0]   b_resp,
  output logic                b_valid,
  input  logic                b_ready,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [LEN_W-1:0]    ar_len,
  input  logic [SIZE_W-1:0]   ar_size,
  input  logic [BURST_W-1:0]  ar_burst,
  input  logic                ar_valid,
  output logic                ar_ready,
  output logic [ID_W-1:0]     r_id,
  output logic [DATA_W-1:0]   r_data,
  output logic [RESP_W-1:0]   r_resp,
  output logic                r_last,
  output logic                r_valid,
  input  logic                r_ready,
  output logic                ram_en,
  output logic [STRB_W-1:0]   ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  state_e          state;
  logic            last_rd;
  logic [ID_W-1:0] id_q;
  ax_ctx_t         ctx;
  logic [4:0]      beat;
  logic [4:0]      issued;
  logic            pend;
  logic            pend_last;
  logic            err;

  logic       grant_rd;
  logic       grant_wr;
  logic       wr_fire;
  logic       rd_issue;
  logic       r_pop;
  logic [1:0] sk_cnt;
  logic [2:0] occ;

  // Read data returns one cycle after issue and is parked in the skid buffer
  axi_skid_buf #(.W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pend),
    .in_data   (ram_rdata),
    .in_last   (pend_last),
    .out_valid (r_valid),
    .out_data  (r_data),
    .out_last  (r_last),
    .out_ready (r_ready),
    .count     (sk_cnt)
  );

  // Arbitration, handshakes and SRAM port driven from registered state
  always_comb begin
    grant_rd  = (state == ST_IDLE) && ar_valid && (!aw_valid || !last_rd);
    grant_wr  = (state == ST_IDLE) && aw_valid && !grant_rd;
    ar_ready  = grant_rd;
    aw_ready  = grant_wr;
    w_ready   = (state == ST_WR);
    wr_fire   = w_ready && w_valid;
    r_pop     = r_valid && r_ready;
    occ       = 3'(sk_cnt) + 3'(pend) - 3'(r_pop);
    rd_issue  = (state == ST_RD) && (occ < 3'd2) && (issued <= {1'b0, ctx.len});
    ram_en    = rd_issue || wr_fire;
    ram_we    = wr_fire ? w_strb : '0;
    ram_addr  = ram_en ? ctx.addr[RAM_AW+1:2] : '0;
    ram_wdata = wr_fire ? w_data : '0;
    r_id      = id_q;
    r_resp    = RESP_OKAY;
    b_valid   = (state == ST_WR_RESP);
    b_id      = id_q;
    b_resp    = (b_valid && err) ? RESP_SLVERR : RESP_OKAY;
  end

  // Burst FSM with latched context, beat counters and write error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_rd   <= 1'b0;
      id_q      <= '0;
      ctx       <= '0;
      beat      <= '0;
      issued    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      err       <= 1'b0;
    end else begin
      pend      <= rd_issue;
      pend_last <= rd_issue && (issued == {1'b0, ctx.len});
      case (state)
        ST_IDLE: begin
          if (grant_rd) begin
            id_q   <= ar_id;
            ctx    <= '{addr: ar_addr, len: ar_len, size: ar_size, burst: ar_burst};
            beat   <= '0;
            issued <= '0;
            state  <= ST_RD;
          end else if (grant_wr) begin
            id_q   <= aw_id;
            ctx    <= '{addr: aw_addr, len: aw_len, size: aw_size, burst: aw_burst};
            beat   <= '0;
            issued <= '0;
            err    <= 1'b0;
            state  <= ST_WR;
          end
        end
        ST_RD: begin
          if (rd_issue) begin
            issued   <= issued + 5'd1;
            ctx.addr <= next_addr(ctx.addr, ctx.size, ctx.len, ctx.burst);
          end
          if (r_pop && r_last) begin
            last_rd <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (wr_fire) begin
            beat     <= beat + 5'd1;
            ctx.addr <= next_addr(ctx.addr, ctx.size, ctx.len, ctx.burst);
            err      <= err | (w_last != (beat == {1'b0, ctx.len}));
            if (beat == {1'b0, ctx.len}) state <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (b_ready) begin
            last_rd <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
